// File: rtl/echo_pkg.sv
// Shared widths, sample limits, FSM state encoding and request payload for the echo/delay stage.
package echo_pkg;

    localparam int unsigned DATA_W = 10;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned SAMP_W = DATA_W + 1;
    localparam int unsigned MIX_W  = DATA_W + 2;

    localparam int MIDSCALE = 512;
    localparam int SMAX     = 511;
    localparam int SMIN     = -512;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        MIX,
        WRITE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] sample_in;
        logic [ADDR_W-1:0] delay;
        logic [1:0]        gain_shift;
    } echo_req_t;

    // Clamp a mix-width signed sum into the signed sample range.
    function automatic logic signed [SAMP_W-1:0] sat_samp(input logic signed [MIX_W-1:0] y);
        if (y > MIX_W'(SMAX)) begin
            return SAMP_W'(SMAX);
        end else if (y < MIX_W'(SMIN)) begin
            return SAMP_W'(SMIN);
        end
        return SAMP_W'(y);
    endfunction

endpackage

// File: rtl/echo_delay_proc_if.sv
// Sample-in / sample-out bus between the ADC front end, the echo stage and the DAC back end.
interface echo_delay_proc_if;
    import echo_pkg::*;

    logic              sample_valid;
    echo_req_t         req;
    logic [DATA_W-1:0] sample_out;
    logic              out_valid;
    logic              busy;

    modport master (
        output sample_valid,
        output req,
        input  sample_out,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  sample_valid,
        input  req,
        output sample_out,
        output out_valid,
        output busy
    );

endinterface

// File: rtl/echo_ram.sv
// Single-port synchronous delay-line RAM with registered read data (maps onto block RAM).
module echo_ram #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 11
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic signed [DW-1:0] wdata,
    output logic signed [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic signed [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/echo_delay_proc.sv
// Echo/delay voice stage: mixes an attenuated delayed sample from a circular buffer with the live input.
// Build option ECHO_FEEDBACK_EN: buffer stores the mixed output (recursive echo) instead of the dry input.
module echo_delay_proc
    import echo_pkg::*;
(
    input  logic               sysclk,
    input  logic               rst_n,
    echo_delay_proc_if.slave   bus
);

    state_t                    state, state_nx;
    logic signed [SAMP_W-1:0]  xs_q, xs_nx;
    logic [ADDR_W-1:0]         dly_q, dly_nx;
    logic [1:0]                gs_q, gs_nx;
    logic [ADDR_W-1:0]         wr_ptr, wr_ptr_nx;
    logic [ADDR_W-1:0]         fill_cnt, fill_nx;
    logic [DATA_W-1:0]         sample_out_q, sample_out_nx;
    logic                      out_valid_q, out_valid_nx;
    logic                      busy_q, busy_nx;

    logic                      ram_we_c;
    logic [ADDR_W-1:0]         ram_addr_c;
    logic signed [SAMP_W-1:0]  ram_wdata_c;
    logic signed [SAMP_W-1:0]  ram_rdata;

    logic signed [SAMP_W-1:0]  d_c;
    logic signed [MIX_W-1:0]   d_ext_c;
    logic signed [MIX_W-1:0]   d_sh_c;
    logic signed [MIX_W-1:0]   y_c;
    logic signed [SAMP_W-1:0]  ysat_c;
    logic signed [SAMP_W-1:0]  so_c;

`ifdef ECHO_FEEDBACK_EN
    logic signed [SAMP_W-1:0]  ysat_q, ysat_nx;
`endif

    // Echo term is suppressed until the buffer actually holds `delay` samples.
    always_comb begin
        d_c     = ((dly_q == '0) || (fill_cnt < dly_q)) ? '0 : ram_rdata;
        d_ext_c = MIX_W'(d_c);
        d_sh_c  = d_ext_c >>> (3'(gs_q) + 3'd1);
        y_c     = MIX_W'(xs_q) + d_sh_c;
        ysat_c  = sat_samp(y_c);
        so_c    = ysat_c + SAMP_W'(MIDSCALE);
    end

    // One address port: write slot during WRITE, delayed read slot otherwise.
    always_comb begin
        ram_we_c   = (state == WRITE) && rst_n;
        ram_addr_c = (state == WRITE) ? wr_ptr : (wr_ptr - dly_q);
`ifdef ECHO_FEEDBACK_EN
        ram_wdata_c = ysat_q;
`else
        ram_wdata_c = xs_q;
`endif
    end

    echo_ram #(
        .AW (ADDR_W),
        .DW (SAMP_W)
    ) u_ram (
        .clk   (sysclk),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (ram_wdata_c),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nx      = state;
        xs_nx         = xs_q;
        dly_nx        = dly_q;
        gs_nx         = gs_q;
        wr_ptr_nx     = wr_ptr;
        fill_nx       = fill_cnt;
        sample_out_nx = sample_out_q;
        out_valid_nx  = 1'b0;
`ifdef ECHO_FEEDBACK_EN
        ysat_nx       = ysat_q;
`endif
        case (state)
            IDLE: begin
                if (bus.sample_valid) begin
                    xs_nx    = $signed({1'b0, bus.req.sample_in}) - SAMP_W'(MIDSCALE);
                    dly_nx   = bus.req.delay;
                    gs_nx    = bus.req.gain_shift;
                    state_nx = READ;
                end
            end
            READ:  state_nx = WAIT;
            WAIT:  state_nx = MIX;
            MIX: begin
                sample_out_nx = so_c[DATA_W-1:0];
                out_valid_nx  = 1'b1;
`ifdef ECHO_FEEDBACK_EN
                ysat_nx       = ysat_c;
`endif
                state_nx      = WRITE;
            end
            WRITE: begin
                wr_ptr_nx = wr_ptr + ADDR_W'(1);
                fill_nx   = (fill_cnt == '1) ? fill_cnt : fill_cnt + ADDR_W'(1);
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state        <= IDLE;
            xs_q         <= '0;
            dly_q        <= '0;
            gs_q         <= '0;
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            sample_out_q <= DATA_W'(MIDSCALE);
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ECHO_FEEDBACK_EN
            ysat_q       <= '0;
`endif
        end else begin
            state        <= state_nx;
            xs_q         <= xs_nx;
            dly_q        <= dly_nx;
            gs_q         <= gs_nx;
            wr_ptr       <= wr_ptr_nx;
            fill_cnt     <= fill_nx;
            sample_out_q <= sample_out_nx;
            out_valid_q  <= out_valid_nx;
            busy_q       <= busy_nx;
`ifdef ECHO_FEEDBACK_EN
            ysat_q       <= ysat_nx;
`endif
        end
    end

    assign bus.sample_out = sample_out_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_echo_delay_proc.sv
// Bench for echo_delay_proc: vector table, corner sequences and randomized traffic against a sample-history model.
module tb_echo_delay_proc;
    import echo_pkg::*;

`ifdef ECHO_FEEDBACK_EN
    localparam int FB = 1;
`else
    localparam int FB = 0;
`endif

    typedef struct {
        int x;
        int dly;
        int g;
        int exp;
    } vec_t;

    logic sysclk = 1'b0;
    logic rst_n;

    echo_delay_proc_if bus ();

    echo_delay_proc dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 sysclk = ~sysclk;

    int n_cmp = 0;
    int n_bad = 0;
    int hist[$];
    vec_t tbl[$];

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: samples since reset form a history; echo reads history[n - delay] when it exists.
    function automatic int model(input int x, input int dly, input int g);
        int n, xs, d, y;
        n  = hist.size();
        xs = x - 512;
        d  = (dly != 0 && n >= dly) ? hist[n - dly] : 0;
        y  = xs + (d >>> (g + 1));
        if (y > 511)  y = 511;
        if (y < -512) y = -512;
        if (FB != 0) hist.push_back(y);
        else         hist.push_back(xs);
        return y + 512;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        repeat (3) @(negedge sysclk);
        check("rst_sample_out", int'(bus.sample_out), 512);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        hist.delete();
        @(negedge sysclk);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic send(input int x, input int dly, input int g, input int noise, output int got);
        int lat;
        bus.req.sample_in  = DATA_W'(x);
        bus.req.delay      = ADDR_W'(dly);
        bus.req.gain_shift = 2'(g);
        bus.sample_valid   = 1'b1;
        @(negedge sysclk);
        bus.sample_valid = 1'b0;
        if (noise != 0) begin
            bus.req.sample_in  = DATA_W'($urandom_range(0, 1023));
            bus.req.delay      = ADDR_W'($urandom_range(0, 8191));
            bus.req.gain_shift = 2'($urandom_range(0, 3));
            bus.sample_valid   = 1'b1;
        end
        lat = 0;
        got = -1;
        for (int i = 2; i <= 9; i++) begin
            @(negedge sysclk);
            bus.sample_valid = 1'b0;
            if (i == 2) check("busy_mid", int'(bus.busy), 1);
            if (bus.out_valid) begin
                lat = i;
                got = int'(bus.sample_out);
                break;
            end
        end
        check("latency", lat, 4);
        @(negedge sysclk);
        check("out_valid_pulse", int'(bus.out_valid), 0);
        check("busy_idle", int'(bus.busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, exp, dly, g, x;
        rst_n = 1'b0;
        bus.sample_valid   = 1'b0;
        bus.req.sample_in  = '0;
        bus.req.delay      = '0;
        bus.req.gain_shift = '0;

        // Constant midscale, long delay, impulse echo, then echo disabled.
        for (int i = 0; i < 5; i++) tbl.push_back('{512, 100, 0, 512});
        tbl.push_back('{1000, 3, 0, 1000});
        tbl.push_back('{512, 3, 0, 512});
        tbl.push_back('{512, 3, 0, 512});
        tbl.push_back('{512, 3, 0, 756});
        tbl.push_back('{512, 3, 0, 512});
        tbl.push_back('{512, 3, 0, 512});
        tbl.push_back('{512, 3, 0, (FB != 0) ? 634 : 512});
        tbl.push_back('{512, 3, 0, 512});
        tbl.push_back('{512, 3, 0, 512});
        tbl.push_back('{512, 3, 0, (FB != 0) ? 573 : 512});
        tbl.push_back('{700, 0, 0, 700});
        tbl.push_back('{700, 0, 3, 700});

        do_reset();
        foreach (tbl[i]) begin
            send(tbl[i].x, tbl[i].dly, tbl[i].g, 0, got);
            void'(model(tbl[i].x, tbl[i].dly, tbl[i].g));
            check($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // Saturation at both rails with a one-sample echo.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(1023, 1, 0, 0, got);
            check("sat_hi_model", got, model(1023, 1, 0));
            if (i > 0) check("sat_hi", got, 1023);
        end
        for (int i = 0; i < 6; i++) begin
            send(0, 1, 0, 0, got);
            check("sat_lo_model", got, model(0, 1, 0));
            if (i > 0) check("sat_lo", got, 0);
        end

        // Reset while in MIX: output must not update and the echo history restarts.
        bus.req.sample_in  = 10'd800;
        bus.req.delay      = 13'd1;
        bus.req.gain_shift = 2'd0;
        bus.sample_valid   = 1'b1;
        @(negedge sysclk);
        bus.sample_valid = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b0;
        @(negedge sysclk);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_sample_out", int'(bus.sample_out), 512);
        check("midrst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        hist.delete();
        send(900, 1, 0, 0, got);
        void'(model(900, 1, 0));
        check("post_rst_first", got, 900);
        send(512, 1, 0, 0, got);
        void'(model(512, 1, 0));
        check("post_rst_echo", got, 706);

        // Randomized traffic with dropped strobes and input churn while busy.
        do_reset();
        dly = 0;
        g = 0;
        for (int i = 0; i < 300; i++) begin
            if (i % 20 == 0) begin
                case ($urandom_range(0, 3))
                    0:       dly = 0;
                    1:       dly = 1;
                    2:       dly = int'($urandom_range(2, 8));
                    default: dly = int'($urandom_range(9, 40));
                endcase
            end
            g = int'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       x = 0;
                1:       x = 1023;
                default: x = int'($urandom_range(0, 1023));
            endcase
            send(x, dly, g, int'($urandom_range(0, 1)), got);
            exp = model(x, dly, g);
            check($sformatf("rand%0d", i), got, exp);
        end

        // Maximum delay across the pointer wrap.
        do_reset();
        g = int'($urandom_range(0, 3));
        for (int i = 0; i < 8200; i++) begin
            x = (i < 8) ? 1023 : int'($urandom_range(0, 1023));
            send(x, 8191, g, 0, got);
            exp = model(x, 8191, g);
            check($sformatf("wrap%0d", i), got, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
